// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the RV32I multi-cycle fetch stage.
// Also holds the next-PC source priority used by the next-PC generator.
package instr_fetch_unit_pkg;

   localparam logic [31:0] NOP_INSTR_WORD = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } fetch_state_e;

   typedef enum logic [1:0] {
      PC_SEQ  = 2'd0,
      PC_REL  = 2'd1,
      PC_JALR = 2'd2
   } npc_sel_e;

   // jalr only qualifies jal; on its own it falls through to the lower priorities
   function automatic npc_sel_e npc_select(input logic branch_taken,
                                           input logic jal,
                                           input logic jalr);
      npc_sel_e sel;
      if (jal && jalr) begin
         sel = PC_JALR;
      end else if (jal || branch_taken) begin
         sel = PC_REL;
      end else begin
         sel = PC_SEQ;
      end
      return sel;
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read channel: request/address out, data/ready back.
interface instr_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;

   modport master (output imem_req, output imem_addr,
                   input  imem_rdata, input imem_ready);
   modport slave  (input  imem_req, input imem_addr,
                   output imem_rdata, output imem_ready);
endinterface

// File: rtl/instr_fetch_unit_next_pc_gen.sv
// Combinational next-PC target, pc+4 and redirect-misalignment flag.
module instr_fetch_unit_next_pc_gen
   import instr_fetch_unit_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic [31:0] imm_ext_i,
   input  logic [31:0] rs1_data_i,
   input  logic        branch_taken_i,
   input  logic        jal_i,
   input  logic        jalr_i,
   output logic [31:0] target_o,
   output logic [31:0] pc_plus4_o,
   output logic        misalign_o
);

   npc_sel_e    sel_s;
   logic [31:0] jalr_sum_s;

   // target selection; all sums wrap silently at 2^32
   always_comb begin
      sel_s      = npc_select(branch_taken_i, jal_i, jalr_i);
      pc_plus4_o = pc_i + 32'd4;
      jalr_sum_s = rs1_data_i + imm_ext_i;
      case (sel_s)
         PC_JALR: target_o = jalr_sum_s & ~32'd1;
         PC_REL:  target_o = pc_i + imm_ext_i;
         PC_SEQ:  target_o = pc_plus4_o;
         default: target_o = pc_plus4_o;
      endcase
      misalign_o = (sel_s != PC_SEQ) && target_o[1];
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC and instruction register, runs the IDLE/REQ/DONE
// handshake to instruction memory with a bounded wait.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned TIMEOUT   = 16,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_WORD
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      fetch_start_i,
   input  logic                      pc_update_i,
   input  logic                      branch_taken_i,
   input  logic                      jal_i,
   input  logic                      jalr_i,
   input  logic [31:0]               imm_ext_i,
   input  logic [31:0]               rs1_data_i,
   instr_fetch_unit_if.master        imem,
   output logic [31:0]               instrCode_o,
   output logic [31:0]               pc_o,
   output logic [31:0]               pc_plus4_o,
   output logic                      fetch_done_o,
   output logic                      fetch_busy_o,
   output logic                      fetch_err_o,
   output logic                      misalign_err_o
);

   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_REQ   = ST_REQ;
   localparam logic [1:0] S_DONE  = ST_DONE;
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   logic [1:0]  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        err_q, err_d;
   logic        mis_q, mis_d;
   logic        req_q, done_q;
   logic [31:0] target_s;
   logic        misalign_s;

   instr_fetch_unit_next_pc_gen u_next_pc_gen (
      .pc_i           (pc_q),
      .imm_ext_i      (imm_ext_i),
      .rs1_data_i     (rs1_data_i),
      .branch_taken_i (branch_taken_i),
      .jal_i          (jal_i),
      .jalr_i         (jalr_i),
      .target_o       (target_s),
      .pc_plus4_o     (pc_plus4_o),
      .misalign_o     (misalign_s)
   );

   // next-state: PC commits only in IDLE so the address is stable for a whole transaction
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      err_d   = err_q;
      mis_d   = mis_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = 8'd0;
            if (pc_update_i) begin
               if (misalign_s) begin
                  mis_d = 1'b1;
               end else begin
                  pc_d = target_s;
               end
            end else begin
               pc_d = pc_q;
            end
            if (fetch_start_i) begin
               state_d = S_REQ;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            if (imem.imem_ready) begin
               instr_d = imem.imem_rdata;
               state_d = S_DONE;
            end else if (cnt_q == TO_LAST) begin
               instr_d = NOP_INSTR;
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // state, datapath and registered status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         err_q   <= 1'b0;
         mis_q   <= 1'b0;
         req_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         err_q   <= err_d;
         mis_q   <= mis_d;
         req_q   <= (state_d == S_REQ);
         done_q  <= (state_d == S_DONE);
      end
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc_q;
   assign instrCode_o    = instr_q;
   assign pc_o           = pc_q;
   assign fetch_done_o   = done_q;
   assign fetch_busy_o   = req_q;
   assign fetch_err_o    = err_q;
   assign misalign_err_o = mis_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: table of redirect vectors, hand
// sequences for the multi-cycle corners, and randomized transactions vs a model.
module tb_instr_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          TO     = 16;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_start, pc_update, branch_taken, jal, jalr;
   logic [31:0] imm_ext, rs1_data;
   logic [31:0] instr_code, pc, pc_plus4;
   logic        fetch_done, fetch_busy, fetch_err, misalign_err;

   instr_fetch_unit_if bus_if ();

   instr_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TO), .NOP_INSTR(NOP)) dut (
      .clk            (clk),
      .reset          (reset),
      .fetch_start_i  (fetch_start),
      .pc_update_i    (pc_update),
      .branch_taken_i (branch_taken),
      .jal_i          (jal),
      .jalr_i         (jalr),
      .imm_ext_i      (imm_ext),
      .rs1_data_i     (rs1_data),
      .imem           (bus_if),
      .instrCode_o    (instr_code),
      .pc_o           (pc),
      .pc_plus4_o     (pc_plus4),
      .fetch_done_o   (fetch_done),
      .fetch_busy_o   (fetch_busy),
      .fetch_err_o    (fetch_err),
      .misalign_err_o (misalign_err)
   );

   always #5 clk = ~clk;

   int          passed = 0;
   int          total  = 0;
   logic [31:0] pc_m, instr_m;
   logic        err_m, mis_m;

   typedef struct {
      logic        br, j, jr;
      logic [31:0] imm, rs1, start_pc, exp_pc;
      logic        exp_mis;
   } vec_t;
   vec_t vecs[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic clear_ctl();
      fetch_start  = 1'b0;
      pc_update    = 1'b0;
      branch_taken = 1'b0;
      jal          = 1'b0;
      jalr         = 1'b0;
      imm_ext      = 32'd0;
      rs1_data     = 32'd0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_ctl();
      bus_if.imem_ready = 1'b0;
      bus_if.imem_rdata = 32'd0;
      tick();
      tick();
      reset   = 1'b0;
      pc_m    = RST_PC;
      instr_m = NOP;
      err_m   = 1'b0;
      mis_m   = 1'b0;
   endtask

   // Architectural next-PC rule: returns the new pc and whether the redirect was rejected.
   function automatic void ref_next(input logic [31:0] cur, input logic br, input logic j,
                                    input logic jr, input logic [31:0] imm,
                                    input logic [31:0] rs1,
                                    output logic [31:0] nxt, output logic bad);
      logic [31:0] t;
      logic        redirect;
      redirect = 1'b1;
      if (j && jr)      t = (rs1 + imm) & 32'hFFFF_FFFE;
      else if (j || br) t = cur + imm;
      else begin
         t        = cur + 32'd4;
         redirect = 1'b0;
      end
      bad = redirect && t[1];
      nxt = bad ? cur : t;
   endfunction

   task automatic commit(input string tag, input logic br, input logic j, input logic jr,
                         input logic [31:0] imm, input logic [31:0] rs1, input bit do_chk);
      logic [31:0] nxt;
      logic        bad;
      ref_next(pc_m, br, j, jr, imm, rs1, nxt, bad);
      branch_taken = br;
      jal          = j;
      jalr         = jr;
      imm_ext      = imm;
      rs1_data     = rs1;
      pc_update    = 1'b1;
      tick();
      clear_ctl();
      pc_m = nxt;
      if (bad) mis_m = 1'b1;
      if (do_chk) begin
         chk({tag, "_pc"}, pc, pc_m);
         chk({tag, "_mis"}, {31'd0, misalign_err}, {31'd0, mis_m});
         chk({tag, "_instr"}, instr_code, instr_m);
      end
   endtask

   task automatic set_pc(input logic [31:0] target);
      commit("set_pc", 1'b0, 1'b1, 1'b0, target - pc_m, 32'd0, 1'b0);
   endtask

   // One fetch with memory answering after w REQ cycles (w >= TO means never).
   task automatic fetch_chk(input string tag, input int w, input logic [31:0] word, input bit poke);
      int lat;
      int n;
      int exp_lat;
      lat         = -1;
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      chk({tag, "_req"}, {31'd0, bus_if.imem_req}, 32'd1);
      chk({tag, "_busy"}, {31'd0, fetch_busy}, 32'd1);
      chk({tag, "_addr"}, bus_if.imem_addr, pc_m);
      n = 1;
      while (n < 60 && lat < 0) begin
         if (fetch_done) begin
            lat = n;
         end else begin
            bus_if.imem_ready = bus_if.imem_req && (n - 1 == w);
            bus_if.imem_rdata = bus_if.imem_ready ? word : 32'hDEAD_BEEF;
            if (poke && n == 2) begin
               fetch_start = 1'b1;
               pc_update   = 1'b1;
               jal         = 1'b1;
               imm_ext     = 32'h0000_0040;
            end
            tick();
            clear_ctl();
            n++;
         end
      end
      bus_if.imem_ready = 1'b0;
      exp_lat = (w < TO) ? w + 2 : TO + 1;
      if (w >= TO) begin
         instr_m = NOP;
         err_m   = 1'b1;
      end else begin
         instr_m = word;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_instr"}, instr_code, instr_m);
      chk({tag, "_err"}, {31'd0, fetch_err}, {31'd0, err_m});
      chk({tag, "_pc_stable"}, pc, pc_m);
      chk({tag, "_req_in_done"}, {31'd0, bus_if.imem_req}, 32'd0);
      tick();
      chk({tag, "_done_pulse"}, {31'd0, fetch_done}, 32'd0);
      chk({tag, "_req_idle"}, {31'd0, bus_if.imem_req}, 32'd0);
      if (poke) begin
         tick();
         chk({tag, "_no_requeue"}, {31'd0, bus_if.imem_req}, 32'd0);
      end
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0,   32'h100,       32'h0F0,  1'b0};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0,   32'h100,       32'h0F0,  1'b0};
      vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h4,         32'h205, 32'h100,       32'h208,  1'b0};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h40,        32'h999, 32'h100,       32'h104,  1'b0};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h40,        32'h0,   32'hFFFF_FFFC, 32'h0,    1'b0};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h20,        32'h10,  32'h100,       32'h030,  1'b0};
      vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h0,         32'h102, 32'h100,       32'h100,  1'b1};

      do_reset();
      chk("rst_pc", pc, RST_PC);
      chk("rst_instr", instr_code, NOP);
      chk("rst_flags", {28'd0, bus_if.imem_req, fetch_done, fetch_busy, fetch_err}, 32'd0);
      chk("rst_mis", {31'd0, misalign_err}, 32'd0);
      chk("rst_addr", bus_if.imem_addr, RST_PC);
      chk("rst_pc_plus4", pc_plus4, 32'd4);

      fetch_chk("zero_wait", 0, 32'h0050_0093, 1'b0);
      fetch_chk("wait3", 3, 32'h0010_0113, 1'b0);
      commit("seq", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      chk("seq_pc4", pc, 32'd4);
      chk("seq_noerr", {30'd0, fetch_err, misalign_err}, 32'd0);

      foreach (vecs[i]) begin
         set_pc(vecs[i].start_pc);
         branch_taken = vecs[i].br;
         jal          = vecs[i].j;
         jalr         = vecs[i].jr;
         imm_ext      = vecs[i].imm;
         rs1_data     = vecs[i].rs1;
         pc_update    = 1'b1;
         tick();
         clear_ctl();
         chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
         chk($sformatf("vec%0d_mis", i), {31'd0, misalign_err}, {31'd0, vecs[i].exp_mis});
         chk($sformatf("vec%0d_plus4", i), pc_plus4, vecs[i].exp_pc + 32'd4);
         pc_m = vecs[i].exp_pc;
         if (vecs[i].exp_mis) mis_m = 1'b1;
      end
      fetch_chk("after_mis", 1, 32'h1234_5678, 1'b0);
      chk("mis_sticky", {31'd0, misalign_err}, 32'd1);

      do_reset();
      chk("mis_cleared", {31'd0, misalign_err}, 32'd0);
      fetch_chk("edge_w15", TO - 1, 32'hCAFE_0001, 1'b0);
      chk("edge_w15_noerr", {31'd0, fetch_err}, 32'd0);
      fetch_chk("timeout", 100, 32'hBAD0_BAD0, 1'b0);
      fetch_chk("post_timeout", 1, 32'h0020_0193, 1'b0);

      do_reset();
      fetch_start = 1'b1;
      pc_update   = 1'b1;
      tick();
      clear_ctl();
      chk("combo_req", {31'd0, bus_if.imem_req}, 32'd1);
      chk("combo_addr", bus_if.imem_addr, 32'd4);
      pc_m = 32'd4;
      bus_if.imem_ready = 1'b1;
      bus_if.imem_rdata = 32'h0000_1117;
      tick();
      bus_if.imem_ready = 1'b0;
      chk("combo_done", {31'd0, fetch_done}, 32'd1);
      chk("combo_instr", instr_code, 32'h0000_1117);
      instr_m = 32'h0000_1117;
      tick();

      fetch_chk("ignore_in_req", 5, 32'h0000_2297, 1'b1);

      set_pc(32'h200);
      fetch_start = 1'b1;
      tick();
      fetch_start = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midreq_req", {31'd0, bus_if.imem_req}, 32'd0);
      chk("midreq_busy", {31'd0, fetch_busy}, 32'd0);
      chk("midreq_pc", pc, RST_PC);
      pc_m = RST_PC; instr_m = NOP; err_m = 1'b0; mis_m = 1'b0;

      for (int k = 0; k < 40; k++) begin
         logic [31:0] imm_r, rs1_r;
         imm_r = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         rs1_r = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         commit($sformatf("rnd%0d_commit", k), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), imm_r, rs1_r, 1'b1);
         fetch_chk($sformatf("rnd%0d_fetch", k), int'($urandom_range(0, 19)), $urandom, 1'b0);
         chk($sformatf("rnd%0d_mis", k), {31'd0, misalign_err}, {31'd0, mis_m});
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Multi-cycle RV32I fetch stage, directly upstream of the control unit. Owns the PC and the instruction register, and drives instrCode for the control unit.
- On a fetch strobe (the control unit's PC_En, asserted in FETCH) it issues a handshaked read to instruction memory and latches the returned word.
- On an instruction-commit strobe it loads the next PC, selected from branch/jal/jalr redirects or pc+4.
- A bus timeout and a misaligned-target check protect against hangs and illegal jumps.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, maximum REQ cycles without imem_ready before the fetch is aborted (range 1..255).
- NOP_INSTR, 32'h0000_0013, word substituted into instrCode on timeout (addi x0,x0,0).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fetch_start  in  1  start-fetch strobe (control unit PC_En)
- pc_update  in  1  commit strobe: load next PC
- branch_taken  in  1  branch & ALU compare true
- jal  in  1  JAL/JALR redirect
- jalr  in  1  JALR (qualifies jal)
- imm_ext  in  32  sign-extended immediate
- rs1_data  in  32  rs1 read data
- imem_req  out  1  instruction memory read request
- imem_addr  out  32  read address (always equals pc)
- imem_rdata  in  32  read data, valid when imem_ready=1
- imem_ready  in  1  read data valid / request accepted
- instrCode  out  32  latched instruction register
- pc  out  32  current PC
- pc_plus4  out  32  pc + 4, for the RFWD mux on J/JL
- fetch_done  out  1  1-cycle pulse: instrCode updated
- fetch_busy  out  1  high while in REQ
- fetch_err  out  1  sticky: a timeout occurred
- misalign_err  out  1  sticky: a redirect target was misaligned

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: pc=RESET_PC, instrCode=NOP_INSTR, imem_req=0, fetch_done=0, fetch_busy=0, fetch_err=0, misalign_err=0, timeout counter=0, state=IDLE. A reset during REQ abandons the transaction; imem_req drops on the next cycle.
- FSM states: IDLE, REQ, DONE.
  - IDLE: fetch_start=1 moves to REQ; the counter clears.
  - REQ: imem_req=1 and fetch_busy=1. imem_ready=1 latches instrCode<=imem_rdata and moves to DONE. Otherwise the counter increments; when the counter reaches TIMEOUT-1 without ready, instrCode<=NOP_INSTR, fetch_err<=1, and the state moves to DONE.
  - DONE: fetch_done=1 for exactly one cycle, then IDLE.
- Latency: fetch_start at cycle t gives imem_req from t+1. With ready at cycle t+1+w, instrCode is valid and fetch_done=1 in cycle t+2+w. Zero-wait memory gives fetch_done at t+2.
- fetch_start in REQ or DONE is ignored; no queuing.
- Next-PC priority, applied on pc_update:
  - jal&jalr: target = (rs1_data+imm_ext) & ~1.
  - else jal or branch_taken: target = pc+imm_ext.
  - else: target = pc+4.
  - All adds are 32-bit modulo; wrap-around at 2^32 is silent.
- Misalignment: a redirect target with target[1]=1 does not update pc and sets misalign_err. The pc+4 path can never misalign.
- pc_update is honoured only in IDLE. In REQ or DONE it is ignored, so pc stays stable during a transaction.
- pc_update and fetch_start in the same IDLE cycle: pc loads the target, and the request issues from t+1 using the new pc.
- imem_addr is driven combinationally from pc. instrCode changes only on fetch completion or reset.

Decomposition:
- Shared package (extend defines): NOP_INSTR constant, fetch state enum (IDLE/REQ/DONE), and a next-PC select enum (PC_SEQ/PC_REL/PC_JALR).
- One natural sub-module: next_pc_gen. It is combinational, computes target, pc_plus4 and the misalign flag, and is verifiable on its own.

Test Plan:
- Zero-wait fetch: reset, fetch_start at t, ready tied 1, rdata=32'h00500093 -> imem_addr=0, fetch_done at t+2, instrCode=32'h00500093.
- Wait states and sequential PC: ready asserted 3 cycles after req, then pc_update with no redirect -> pc 0->4, fetch_done 5 cycles after start, no error flags.
- Redirects with pc=0x100, imm_ext=0xFFFFFFF0:
  - branch_taken -> pc=0xF0.
  - jal -> pc=0xF0.
  - jal&jalr with rs1=0x205 and imm=4 -> pc=0x208 (bit0 cleared).
- Misaligned jalr: rs1=0x102, imm=0 -> pc unchanged at 0x100, misalign_err=1 and stays 1 until reset.
- Timeout: ready held 0 for TIMEOUT=16 cycles -> instrCode=32'h00000013, fetch_err=1, fetch_done pulses once, imem_req drops. A later normal fetch succeeds and fetch_err remains 1.
- Boundary and reset cases:
  - pc_update+fetch_start together with pc=0x0: imem_addr=4 on the request cycle.
  - fetch_start during REQ is ignored.
  - reset mid-REQ: pc=RESET_PC, imem_req=0 next cycle.
  - pc=0xFFFFFFFC with no redirect: pc wraps to 0.
